phoenix_led_sequencer: RTL and testbench

//   Sequences the LED PWM generator through fade-in / hold / fade-out / hold cycles.

---
 rtl/phoenix_led_sequencer_if.sv | 32 +++
 rtl/phoenix_led_sequencer.sv | 171 +++++++++++++++++
 tb/tb_phoenix_led_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/phoenix_led_sequencer_if.sv
// Command channel between host/control logic and the LED sequencer.
// The host (master) issues pattern commands and abort; the sequencer (slave) returns cmd_ready.
interface phoenix_led_sequencer_if #(
    parameter int unsigned PwmCounterBits = 32,
    parameter int unsigned HoldBits       = 16,
    parameter int unsigned RepeatBits     = 8
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [PwmCounterBits-1:0] cmd_step;
    logic [HoldBits-1:0]       cmd_hold;
    logic [RepeatBits-1:0]     cmd_repeat;
    logic                      abort;

    modport master (
        output cmd_valid,
        output cmd_step,
        output cmd_hold,
        output cmd_repeat,
        output abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_step,
        input  cmd_hold,
        input  cmd_repeat,
        input  abort,
        output cmd_ready
    );
endinterface

// File: rtl/phoenix_led_sequencer.sv
// LED fade sequencer: drives a PWM generator through fade-in / hold / fade-out / hold cycles,
// advancing one step per PWM period and running a finite or endless number of cycles.
module phoenix_led_sequencer #(
    parameter int unsigned ClockFrequency = 25_000_000,
    parameter int unsigned PwmCounterBits = 32,
    parameter int unsigned PwmCycle       = ClockFrequency / 1000,
    parameter int unsigned HoldBits       = 16,
    parameter int unsigned RepeatBits     = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          period_tick_i,
    phoenix_led_sequencer_if.slave        cmd,
    output logic [PwmCounterBits-1:0]     pwm_cycle_o,
    output logic [PwmCounterBits-1:0]     pwm_duty_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam logic [PwmCounterBits-1:0] CycleVal = PwmCounterBits'(PwmCycle);
    localparam logic [PwmCounterBits:0]   CycleExt = {1'b0, CycleVal};

    typedef enum logic [2:0] {
        StIdle,
        StFadeIn,
        StHoldOn,
        StFadeOut,
        StHoldOff
    } state_e;

    state_e                    state_q, state_d;
    logic [PwmCounterBits-1:0] duty_q, duty_d;
    logic [PwmCounterBits-1:0] step_q, step_d;
    logic [HoldBits-1:0]       hold_q, hold_d;
    logic [RepeatBits-1:0]     repeat_q, repeat_d;
    logic [HoldBits-1:0]       hold_cnt_q, hold_cnt_d;
    logic [RepeatBits-1:0]     rep_cnt_q, rep_cnt_d;
    logic                      done_q, done_d;

    logic [PwmCounterBits:0]   sum;
    logic [HoldBits-1:0]       hold_cnt_inc;
    logic [RepeatBits-1:0]     rep_cnt_inc;
    logic                      cycle_end;

    assign cmd.cmd_ready = (state_q == StIdle) && !cmd.abort;
    assign pwm_cycle_o   = CycleVal;
    assign pwm_duty_o    = duty_q;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;

    assign sum          = {1'b0, duty_q} + {1'b0, step_q};
    assign hold_cnt_inc = hold_cnt_q + HoldBits'(1);
    assign rep_cnt_inc  = rep_cnt_q + RepeatBits'(1);

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        step_d     = step_q;
        hold_d     = hold_q;
        repeat_d   = repeat_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        done_d     = 1'b0;
        cycle_end  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Ticks are ignored here, including one coincident with the accept.
                if (cmd.cmd_valid && cmd.cmd_ready) begin
                    step_d     = cmd.cmd_step;
                    hold_d     = cmd.cmd_hold;
                    repeat_d   = cmd.cmd_repeat;
                    duty_d     = '0;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                    state_d    = StFadeIn;
                end
            end
            StFadeIn: begin
                if (period_tick_i) begin
                    if (sum >= CycleExt || step_q == '0) begin
                        duty_d  = CycleVal;
                        state_d = (hold_q != '0) ? StHoldOn : StFadeOut;
                    end else begin
                        duty_d = sum[PwmCounterBits-1:0];
                    end
                end
            end
            StHoldOn: begin
                if (period_tick_i) begin
                    if (hold_cnt_inc == hold_q) begin
                        hold_cnt_d = '0;
                        state_d    = StFadeOut;
                    end else begin
                        hold_cnt_d = hold_cnt_inc;
                    end
                end
            end
            StFadeOut: begin
                if (period_tick_i) begin
                    if (duty_q <= step_q || step_q == '0) begin
                        duty_d = '0;
                        if (hold_q != '0) begin
                            state_d = StHoldOff;
                        end else begin
                            cycle_end = 1'b1;
                        end
                    end else begin
                        duty_d = duty_q - step_q;
                    end
                end
            end
            StHoldOff: begin
                if (period_tick_i) begin
                    if (hold_cnt_inc == hold_q) begin
                        hold_cnt_d = '0;
                        cycle_end  = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_inc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A repeat count of zero loops forever until abort.
        if (cycle_end) begin
            if (repeat_q == '0) begin
                state_d = StFadeIn;
            end else if (rep_cnt_inc == repeat_q) begin
                rep_cnt_d = '0;
                done_d    = 1'b1;
                state_d   = StIdle;
            end else begin
                rep_cnt_d = rep_cnt_inc;
                state_d   = StFadeIn;
            end
        end

        if (cmd.abort) begin
            state_d    = StIdle;
            duty_d     = '0;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            duty_q     <= '0;
            step_q     <= '0;
            hold_q     <= '0;
            repeat_q   <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            repeat_q   <= repeat_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_phoenix_led_sequencer.sv
// Scoreboard bench for phoenix_led_sequencer: expected duty changes and done pulses are queued
// as commands are issued; a monitor pops them as the DUT output changes.
module tb_phoenix_led_sequencer;

    localparam int unsigned W  = 32;
    localparam int unsigned HB = 16;
    localparam int unsigned RB = 8;

    typedef struct {
        bit          is_done;
        logic [31:0] duty;
    } ev_t;

    logic          clk;
    logic          rst_n;
    logic          period_tick;
    logic          tick_en;
    logic [W-1:0]  pwm_cycle;
    logic [W-1:0]  pwm_duty;
    logic          busy;
    logic          done;
    int            tick_cnt;
    logic [31:0]   prev_duty;
    ev_t           exp_q[$];
    int            n_checks;
    int            n_errors;

    phoenix_led_sequencer_if #(
        .PwmCounterBits(W),
        .HoldBits      (HB),
        .RepeatBits    (RB)
    ) cmd_if ();

    phoenix_led_sequencer #(
        .ClockFrequency(100_000),
        .PwmCounterBits(W),
        .PwmCycle      (100),
        .HoldBits      (HB),
        .RepeatBits    (RB)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .period_tick_i(period_tick),
        .cmd          (cmd_if.slave),
        .pwm_cycle_o  (pwm_cycle),
        .pwm_duty_o   (pwm_duty),
        .busy_o       (busy),
        .done_o       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Period tick: one-clock pulse every 10 clocks.
    initial begin
        tick_cnt    = 0;
        period_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_cnt    = (tick_cnt == 9) ? 0 : tick_cnt + 1;
            period_tick = (tick_cnt == 9) && tick_en;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_event(input bit is_done, input logic [31:0] duty);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: got done=%0d duty=%0d expected none", is_done, duty);
        end else begin
            e = exp_q.pop_front();
            if (e.is_done != is_done || (!is_done && e.duty !== duty)) begin
                n_errors++;
                $display("FAIL event_seq: got done=%0d duty=%0d expected done=%0d duty=%0d",
                         is_done, duty, e.is_done, e.duty);
            end
        end
    endtask

    // Monitor: every duty change and every done pulse is one observed event.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_duty = '0;
        end else begin
            if (pwm_duty !== prev_duty) begin
                compare_event(1'b0, pwm_duty);
                prev_duty = pwm_duty;
            end
            if (done === 1'b1) compare_event(1'b1, '0);
        end
    end

    task automatic push_duty(input logic [31:0] d);
        ev_t e;
        e.is_done = 1'b0;
        e.duty    = d;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        ev_t e;
        e.is_done = 1'b1;
        e.duty    = '0;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got %0d pending events expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic issue_cmd(input int step, input int hold, input int rep, input bit align);
        if (align) begin
            do @(posedge clk); while (tick_cnt != 8);
        end
        @(negedge clk);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_step   = W'(step);
        cmd_if.cmd_hold   = HB'(hold);
        cmd_if.cmd_repeat = RB'(rep);
        #1 check("ready_at_issue", 32'(cmd_if.cmd_ready), 1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 1);
        check("duty_after_accept", pwm_duty, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        rst_n             = 1'b0;
        tick_en           = 1'b1;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_step   = '0;
        cmd_if.cmd_hold   = '0;
        cmd_if.cmd_repeat = '0;
        cmd_if.abort      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_duty", pwm_duty, 0);
        check("reset_cycle", pwm_cycle, 100);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_ready", 32'(cmd_if.cmd_ready), 1);
        rst_n = 1'b1;

        // 1: async reset in the middle of a fade-in
        issue_cmd(30, 2, 1, 1'b0);
        push_duty(30);
        wait_drain("t1", 40);
        #2 rst_n = 1'b0;
        #1;
        check("t1_duty", pwm_duty, 0);
        check("t1_busy", 32'(busy), 0);
        check("t1_ready", 32'(cmd_if.cmd_ready), 1);
        check("t1_cycle", pwm_cycle, 100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 2 + 5: full single cycle with a conflicting command held while busy
        issue_cmd(30, 2, 1, 1'b0);
        push_duty(30); push_duty(60); push_duty(90); push_duty(100);
        push_duty(70); push_duty(40); push_duty(10); push_duty(0);
        push_done();
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_step   = W'(7);
        cmd_if.cmd_hold   = '0;
        cmd_if.cmd_repeat = RB'(3);
        #1 check("t5_ready_busy", 32'(cmd_if.cmd_ready), 0);
        repeat (30) @(negedge clk);
        check("t5_ready_busy_late", 32'(cmd_if.cmd_ready), 0);
        cmd_if.cmd_valid = 1'b0;
        wait_drain("t2", 300);
        @(negedge clk);
        check("t2_busy_end", 32'(busy), 0);
        check("t2_duty_end", pwm_duty, 0);

        // 3: zero step, zero hold, two repeats
        issue_cmd(0, 0, 2, 1'b0);
        push_duty(100); push_duty(0); push_duty(100); push_duty(0); push_done();
        wait_drain("t3", 100);
        @(negedge clk);
        check("t3_busy_end", 32'(busy), 0);

        // 4: endless pattern stopped by abort after 7 ticks
        issue_cmd(50, 0, 0, 1'b0);
        push_duty(50); push_duty(100); push_duty(50); push_duty(0);
        push_duty(50); push_duty(100); push_duty(50);
        wait_drain("t4", 150);
        cmd_if.abort = 1'b1;
        push_duty(0);
        @(negedge clk);
        cmd_if.abort = 1'b0;
        check("t4_busy_abort", 32'(busy), 0);
        check("t4_duty_abort", pwm_duty, 0);
        repeat (30) @(negedge clk);
        wait_drain("t4_tail", 5);

        // 5b: abort together with cmd_valid in IDLE must not accept
        cmd_if.cmd_valid = 1'b1;
        cmd_if.abort     = 1'b1;
        cmd_if.cmd_step  = W'(20);
        #1 check("t5_ready_abort", 32'(cmd_if.cmd_ready), 0);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.abort     = 1'b0;
        check("t5_busy_abort", 32'(busy), 0);
        repeat (25) @(negedge clk);
        check("t5_duty_idle", pwm_duty, 0);

        // 6: tick coincident with accept is ignored
        issue_cmd(50, 0, 1, 1'b1);
        push_duty(50); push_duty(100); push_duty(50); push_duty(0); push_done();
        repeat (5) @(negedge clk);
        check("t6_duty_no_step", pwm_duty, 0);
        wait_drain("t6", 100);
        @(negedge clk);
        check("t6_busy_end", 32'(busy), 0);

        repeat (20) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
